julia_render: RTL and testbench

Frame renderer that consumes the parameter set produced by the front-panel parameter-entry stage (`c_real`, `c_comp`, `x`, `y`, `scale`, `valid`). For every pixel it forms z0 from the captured origin and step, iterates z ← z² + c in 18-bit fixed point until escape or `MAX_ITER`, and writes the iteration count to the frame buffer through a valid/ready write port. One frame is rendered per rising edge of `valid`.

---
 rtl/julia_render.sv | 186 ++++++++++++++++++
 tb/tb_julia_render.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/julia_render.sv
// Julia-set frame renderer: walks every pixel of a frame, iterates z <- z^2 + c in
// signed 4.14 fixed point and streams the escape count to a frame buffer.
module julia_render #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480,
    parameter int MAX_ITER = 255,
    parameter int FRAC     = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               valid,
    input  logic signed [17:0] c_real,
    input  logic signed [17:0] c_comp,
    input  logic signed [17:0] x,
    input  logic signed [17:0] y,
    input  logic signed [17:0] scale,
    output logic [18:0]        wr_addr,
    output logic [7:0]         wr_data,
    output logic               wr_en,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done
);

    localparam int CW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
    localparam int RW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(H_PIXELS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_PIXELS - 1);
    localparam logic [7:0]    ITER_CAP = 8'(MAX_ITER);
    localparam logic signed [36:0] ESC_LIMIT = 37'sd1 <<< (2 * FRAC + 2);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ITER, S_WRITE, S_NEXT, S_DONE} state_t;

    // Rescale a full-precision product back to 4.14, keeping only the low 18 bits.
    function automatic logic signed [17:0] fx_trunc(input logic signed [36:0] v);
        return 18'(v >>> FRAC);
    endfunction

    state_t             state_q, state_d;
    logic               valid_d_q;
    logic signed [17:0] c_real_q, c_real_d, c_comp_q, c_comp_d;
    logic signed [17:0] x_q, x_d, scale_q, scale_d;
    logic signed [17:0] zr0_q, zr0_d, zi0_q, zi0_d;
    logic signed [17:0] zr_q, zr_d, zi_q, zi_d;
    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [18:0]        addr_q, addr_d;
    logic [7:0]         iter_q, iter_d, count_q, count_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic signed [35:0] zr_sq, zi_sq, zri;
    logic signed [36:0] mag, diff, twice;
    logic               escape, start;

    assign zr_sq  = zr_q * zr_q;
    assign zi_sq  = zi_q * zi_q;
    assign zri    = zr_q * zi_q;
    assign mag    = $signed({zr_sq[35], zr_sq}) + $signed({zi_sq[35], zi_sq});
    assign diff   = $signed({zr_sq[35], zr_sq}) - $signed({zi_sq[35], zi_sq});
    assign twice  = $signed({zri, 1'b0});
    assign escape = mag > ESC_LIMIT;
    assign start  = valid & ~valid_d_q;

    always_comb begin
        state_d  = state_q;
        c_real_d = c_real_q;
        c_comp_d = c_comp_q;
        x_d      = x_q;
        scale_d  = scale_q;
        zr0_d    = zr0_q;
        zi0_d    = zi0_q;
        zr_d     = zr_q;
        zi_d     = zi_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        iter_d   = iter_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    c_real_d = c_real;
                    c_comp_d = c_comp;
                    x_d      = x;
                    scale_d  = scale;
                    zr0_d    = x;
                    zi0_d    = y;
                    col_d    = '0;
                    row_d    = '0;
                    addr_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                zr_d    = zr0_q;
                zi_d    = zi0_q;
                iter_d  = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (escape || iter_q == ITER_CAP) begin
                    count_d = iter_q;
                    state_d = S_WRITE;
                end else begin
                    zr_d   = fx_trunc(diff) + c_real_q;
                    zi_d   = fx_trunc(twice) + c_comp_q;
                    iter_d = iter_q + 8'd1;
                end
            end
            S_WRITE: begin
                if (wr_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (col_q == COL_LAST) begin
                    col_d   = '0;
                    row_d   = row_q + 1'b1;
                    zr0_d   = x_q;
                    zi0_d   = zi0_q + scale_q;
                    addr_d  = addr_q + 19'd1;
                    state_d = S_INIT;
                end else begin
                    col_d   = col_q + 1'b1;
                    zr0_d   = zr0_q + scale_q;
                    addr_d  = addr_q + 19'd1;
                    state_d = S_INIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            valid_d_q <= 1'b0;
            c_real_q  <= '0;
            c_comp_q  <= '0;
            x_q       <= '0;
            scale_q   <= '0;
            zr0_q     <= '0;
            zi0_q     <= '0;
            zr_q      <= '0;
            zi_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            iter_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_d_q <= valid;
            c_real_q  <= c_real_d;
            c_comp_q  <= c_comp_d;
            x_q       <= x_d;
            scale_q   <= scale_d;
            zr0_q     <= zr0_d;
            zi0_q     <= zi0_d;
            zr_q      <= zr_d;
            zi_q      <= zi_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            iter_q    <= iter_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign wr_en   = (state_q == S_WRITE);
    assign wr_addr = addr_q;
    assign wr_data = count_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_julia_render.sv
// Directed bench for julia_render on a 4x2 frame with hand-computed escape counts.
module tb_julia_render;

    localparam int NPIX = 8;
    typedef logic [7:0] frame_t [NPIX];

    logic               clock = 1'b0;
    logic               reset;
    logic               valid;
    logic signed [17:0] c_real, c_comp, x, y, scale;
    logic [18:0]        wr_addr;
    logic [7:0]         wr_data;
    logic               wr_en;
    logic               wr_ready;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [18:0] waddr_log[$];
    logic [7:0]  wdata_log[$];
    int          wcyc_log[$];

    julia_render #(
        .H_PIXELS(4),
        .V_PIXELS(2),
        .MAX_ITER(255),
        .FRAC(14)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .valid   (valid),
        .c_real  (c_real),
        .c_comp  (c_comp),
        .x       (x),
        .y       (y),
        .scale   (scale),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .wr_ready(wr_ready),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Inputs only change 1ns after a rising edge, so the negedge view is what the next edge sees.
    always @(negedge clock) begin
        if (reset && wr_en && wr_ready) begin
            waddr_log.push_back(wr_addr);
            wdata_log.push_back(wr_data);
            wcyc_log.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        waddr_log.delete();
        wdata_log.delete();
        wcyc_log.delete();
    endtask

    task automatic start_frame(input logic signed [17:0] cr, input logic signed [17:0] ci,
                               input logic signed [17:0] x0, input logic signed [17:0] y0,
                               input logic signed [17:0] s);
        c_real = cr;
        c_comp = ci;
        x      = x0;
        y      = y0;
        scale  = s;
        valid  = 1'b1;
        step(1);
        valid  = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        int n;
        n = 0;
        while (!done && n < budget) begin
            step(1);
            n++;
        end
        dcyc = cyc;
        check("done_wait", done, 1);
    endtask

    task automatic check_frame(input string tag, input frame_t exp);
        check({tag, "_nwr"}, waddr_log.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < waddr_log.size()) begin
                check({tag, "_addr"}, waddr_log[i], i);
                check({tag, "_data"}, wdata_log[i], exp[i]);
            end
        end
    endtask

    initial begin
        frame_t e;
        int     dc;
        int     n;

        reset    = 1'b0;
        valid    = 1'b0;
        wr_ready = 1'b1;
        c_real   = '0;
        c_comp   = '0;
        x        = '0;
        y        = '0;
        scale    = '0;

        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        step(100);
        check("idle_no_write", waddr_log.size(), 0);
        check("idle_busy", busy, 0);

        // Everything zero: z stays at the origin, every pixel hits the cap.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0, 18'sh0, 18'sh0);
        check("start_busy", busy, 1);
        check("start_wr_en", wr_en, 0);
        wait_done(5000, dc);
        e = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        check_frame("cap", e);
        if (wcyc_log.size() == NPIX) check("done_latency", dc - wcyc_log[NPIX-1], 2);
        check("done_busy_low", busy, 0);

        // z0 = 3.0 escapes on the first test; 4 cycles per pixel.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0C000, 18'sh0, 18'sh0);
        wait_done(5000, dc);
        e = '{default: 8'd0};
        check_frame("esc", e);
        for (int i = 1; i < NPIX; i++) begin
            if (i < wcyc_log.size()) check("esc_spacing", wcyc_log[i] - wcyc_log[i-1], 4);
        end

        // |z|^2 == 4.0 exactly must not escape; next step is 16.0.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh08000, 18'sh0, 18'sh0);
        wait_done(5000, dc);
        e = '{default: 8'd1};
        check_frame("eq4", e);

        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh06000, 18'sh0, 18'sh0);
        wait_done(5000, dc);
        check_frame("x1p5", e);

        // c = -1: orbit 1 -> 0 -> -1 -> 0 never escapes.
        clear_log();
        start_frame(18'sh3C000, 18'sh0, 18'sh04000, 18'sh0, 18'sh0);
        wait_done(5000, dc);
        e = '{default: 8'd255};
        check_frame("orbit", e);

        // Step 3.0: only the origin pixel stays bounded.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0, 18'sh0, 18'sh0C000);
        wait_done(5000, dc);
        e = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_frame("step3", e);

        // Step 0.5: row 1 must restart real part at x, imag at 0.5.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0, 18'sh0, 18'sh02000);
        wait_done(5000, dc);
        e = '{8'd255, 8'd255, 8'd255, 8'd1, 8'd255, 8'd255, 8'd3, 8'd1};
        check_frame("step05", e);

        // Backpressure on pixel 2, then reset during pixel 3.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0C000, 18'sh0, 18'sh0);
        n = 0;
        while (!(wr_en && wr_addr == 19'd2) && n < 200) begin
            step(1);
            n++;
        end
        check("bp_reach", (wr_en && wr_addr == 19'd2), 1);
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("bp_wr_en", wr_en, 1);
            check("bp_wr_addr", wr_addr, 2);
            check("bp_wr_data", wr_data, 0);
        end
        check("bp_nwr", waddr_log.size(), 2);
        wr_ready = 1'b1;
        step(1);
        check("bp_release_nwr", waddr_log.size(), 3);
        step(1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_wr_en", wr_en, 0);
        check("arst_busy", busy, 0);
        check("arst_wr_addr", wr_addr, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_done", done, 0);
        step(1);
        reset = 1'b1;
        step(20);
        check("post_rst_nwr", waddr_log.size(), 3);
        check("post_rst_busy", busy, 0);

        // Restart after reset; a second rising edge mid-frame must be ignored.
        clear_log();
        start_frame(18'sh0, 18'sh0, 18'sh0C000, 18'sh0, 18'sh0);
        check("restart_addr", wr_addr, 0);
        step(6);
        valid = 1'b1;
        step(2);
        valid = 1'b0;
        wait_done(5000, dc);
        e = '{default: 8'd0};
        check_frame("reedge", e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
